// File: rtl/axi_mgr_wr_ostd_if.sv
// AXI4 write-manager channel bundle and DMA burst-request bundle used by axi_mgr_wr_ostd.
interface axi_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int UW = 32,
   parameter int IW = 1
) ();
   logic            awvalid;
   logic            awready;
   logic [IW-1:0]   awid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awlock;
   logic [UW-1:0]   awuser;
   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;
   logic [UW-1:0]   wuser;
   logic            bvalid;
   logic            bready;
   logic [IW-1:0]   bid;
   logic [1:0]      bresp;

   modport w_mgr (
      output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awuser,
      output wvalid, wdata, wstrb, wlast, wuser, bready,
      input  awready, wready, bvalid, bid, bresp
   );
endinterface

interface axi_dma_req_if #(
   parameter int AW = 32,
   parameter int LW = 16
) ();
   logic [AW-1:0] addr;
   logic [LW-1:0] byte_len;
   logic          fixed;
   logic          lock;
   logic          valid;
   logic          ready;
   logic [1:0]    resp;
   logic          resp_valid;

   modport snk (
      input  addr, byte_len, fixed, lock, valid,
      output ready, resp, resp_valid
   );
endinterface

// File: rtl/axi_mgr_wr_ostd.sv
// AXI4 write manager with up to MAX_OSTD bursts in flight; W strobes come from a per-burst context FIFO.
// Optional AXI_MGR_WR_BRESP_TIMEOUT_EN adds a B-response watchdog (TIMEOUT, timeout_o). Assumes DW >= 16.
module axi_mgr_wr_ostd #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int UW       = 32,
   parameter int IW       = 1,
   parameter int MAX_OSTD = 4
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 1024
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   axi_if.w_mgr                      m_axi_if,
   axi_dma_req_if.snk                req_if,
   input  logic [UW-1:0]             axuser,
   input  logic                      valid_i,
   input  logic [DW-1:0]             data_i,
   output logic                      ready_o,
   output logic [$clog2(MAX_OSTD):0] ostd_cnt_o,
   output logic                      err_o
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
   ,
   output logic                      timeout_o
`endif
);
   localparam int BC = DW / 8;
   localparam int BW = $clog2(BC);
   localparam int CW = $clog2(MAX_OSTD) + 1;
   localparam int PW = (MAX_OSTD > 1) ? $clog2(MAX_OSTD) : 1;
   localparam int LW = 16;

   typedef struct packed {
      logic [7:0]    len;
      logic [BC-1:0] first;
      logic [BC-1:0] last;
      logic          fixed;
   } ctx_t;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OSTD - 1)) ? '0 : p + PW'(1);
   endfunction

   logic          req_hs, aw_hs, w_hs, b_hs, push, pop, active, blocked, mid;
   logic [BW-1:0] req_off, end_off;
   logic [LW:0]   req_beats;
   logic [CW:0]   slots;
   logic [CW-1:0] ctx_cnt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    rem, cur;
   ctx_t          pend_ctx, head;
   ctx_t          ctx_mem [MAX_OSTD];

   // Request decode: the offset term vanishes for FIXED so every beat is a full lane.
   assign req_off   = req_if.fixed ? '0 : req_if.addr[BW-1:0];
   assign end_off   = req_if.addr[BW-1:0] + req_if.byte_len[BW-1:0] - BW'(1);
   assign req_beats = ({1'b0, req_if.byte_len} + (LW+1)'(req_off) + (LW+1)'(BC - 1)) >> BW;

   // A pending AW already owns a slot; a B retiring this cycle frees one.
   assign slots  = {1'b0, ostd_cnt_o} + (CW+1)'(m_axi_if.awvalid) - (CW+1)'(b_hs);
   assign req_if.ready = !rst && !blocked && (slots < (CW+1)'(MAX_OSTD)) &&
                         (ctx_cnt != CW'(MAX_OSTD)) && (!m_axi_if.awvalid || m_axi_if.awready);
   assign req_hs = req_if.valid && req_if.ready;
   assign aw_hs  = m_axi_if.awvalid && m_axi_if.awready;
   assign w_hs   = m_axi_if.wvalid && m_axi_if.wready;
   assign b_hs   = m_axi_if.bvalid && m_axi_if.bready && (ostd_cnt_o != '0);
   assign push   = aw_hs;
   assign pop    = w_hs && m_axi_if.wlast;

   assign m_axi_if.awsize = 3'(BW);
   assign m_axi_if.awid   = '0;
   assign m_axi_if.awuser = axuser;
   assign m_axi_if.bready = 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) m_axi_if.awvalid <= 1'b0;
      else if (req_hs) m_axi_if.awvalid <= 1'b1;
      else if (aw_hs) m_axi_if.awvalid <= 1'b0;
   end

   // NOTE: payload registers and the context RAM are qualified by valid/count flops and need no reset.
   always_ff @(posedge clk) begin
      if (req_hs) begin
         m_axi_if.awaddr  <= req_if.addr;
         m_axi_if.awlen   <= 8'(req_beats - (LW+1)'(1));
         m_axi_if.awburst <= req_if.fixed ? 2'b00 : 2'b01;
         m_axi_if.awlock  <= req_if.lock;
         pend_ctx.len     <= 8'(req_beats - (LW+1)'(1));
         pend_ctx.first   <= req_if.fixed ? '1 : ({BC{1'b1}} << req_off);
         pend_ctx.last    <= req_if.fixed ? '1 : ({BC{1'b1}} >> (BW'(BC - 1) - end_off));
         pend_ctx.fixed   <= req_if.fixed;
      end
      if (push) ctx_mem[wr_ptr] <= pend_ctx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ctx_cnt    <= '0;
         ostd_cnt_o <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         ctx_cnt    <= ctx_cnt + CW'(push) - CW'(pop);
         ostd_cnt_o <= ostd_cnt_o + CW'(aw_hs) - CW'(b_hs);
      end
   end

   // W channel: the head context drives the beat down-counter and strobe selection.
   assign head             = ctx_mem[rd_ptr];
   assign active           = !rst && (ctx_cnt != '0);
   assign cur              = mid ? rem : head.len;
   assign m_axi_if.wvalid  = active && valid_i;
   assign ready_o          = active && m_axi_if.wready;
   assign m_axi_if.wdata   = data_i;
   assign m_axi_if.wuser   = axuser;
   assign m_axi_if.wlast   = (cur == 8'd0);

   // NOTE: always_comb assigns its output a default first so no path can infer a latch.
   always_comb begin
      m_axi_if.wstrb = '1;
      if (head.fixed) m_axi_if.wstrb = '1;
      else if (head.len == 8'd0) m_axi_if.wstrb = head.first & head.last;
      else if (!mid) m_axi_if.wstrb = head.first;
      else if (cur == 8'd0) m_axi_if.wstrb = head.last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mid <= 1'b0;
         rem <= '0;
      end else if (w_hs) begin
         mid <= !m_axi_if.wlast;
         rem <= cur - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_if.resp_valid <= 1'b0;
         req_if.resp       <= 2'b00;
         err_o             <= 1'b0;
      end else begin
         req_if.resp_valid <= b_hs;
         if (b_hs) req_if.resp <= m_axi_if.bresp;
         if (b_hs && m_axi_if.bresp[1]) err_o <= 1'b1;
      end
   end

`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt   <= '0;
         timeout_o <= 1'b0;
      end else if (ostd_cnt_o == '0 || b_hs) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TW'(TIMEOUT)) begin
         tmo_cnt <= tmo_cnt + TW'(1);
         if (tmo_cnt + TW'(1) == TW'(TIMEOUT)) timeout_o <= 1'b1;
      end
   end
   assign blocked = timeout_o;
`else
   assign blocked = 1'b0;
`endif

   a_ready_active : assert property (@(posedge clk) disable iff (rst) ready_o |-> active);
   a_wvalid_data  : assert property (@(posedge clk) disable iff (rst) m_axi_if.wvalid |-> valid_i);
   a_aw_sat       : assert property (@(posedge clk) disable iff (rst) aw_hs |-> (ostd_cnt_o != CW'(MAX_OSTD)));
   a_ctx_ovf      : assert property (@(posedge clk) disable iff (rst) push |-> (ctx_cnt != CW'(MAX_OSTD) || pop));
   a_len_zero     : assert property (@(posedge clk) disable iff (rst) req_hs |-> (req_if.byte_len != '0));
   a_4k_cross     : assert property (@(posedge clk) disable iff (rst) (req_hs && !req_if.fixed) |->
                       ((17'(req_if.addr[11:0]) + 17'(req_if.byte_len)) <= 17'd4096));
   a_len_max      : assert property (@(posedge clk) disable iff (rst) req_hs |->
                       (req_beats <= (req_if.fixed ? (LW+1)'(16) : (LW+1)'(256))));
   a_fixed_align  : assert property (@(posedge clk) disable iff (rst) (req_hs && req_if.fixed) |->
                       (req_if.addr[BW-1:0] == '0 && req_if.byte_len[BW-1:0] == '0));
   a_b_legal      : assert property (@(posedge clk) disable iff (rst) m_axi_if.bvalid |->
                       (ostd_cnt_o != '0 && m_axi_if.bid == '0));
endmodule

// File: tb/tb_axi_mgr_wr_ostd.sv
// Directed bench for axi_mgr_wr_ostd: alignment, strobes, outstanding limit, back-to-back W, errors, reset.
module tb_axi_mgr_wr_ostd;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] axuser = 32'h1234_5678;
   logic        valid_i = 1'b0;
   logic [31:0] data_i = 32'hCAFE_0001;
   logic        ready_o;
   logic [2:0]  ostd_cnt;
   logic        err_o;
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
   logic        timeout_o;
`endif

   axi_if #(.AW(32), .DW(32), .UW(32), .IW(1)) axi ();
   axi_dma_req_if #(.AW(32), .LW(16)) req ();

   axi_mgr_wr_ostd #(
      .AW(32), .DW(32), .UW(32), .IW(1), .MAX_OSTD(4)
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_axi_if   (axi),
      .req_if     (req),
      .axuser     (axuser),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .ostd_cnt_o (ostd_cnt),
      .err_o      (err_o)
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
      , .timeout_o (timeout_o)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int b_cyc = 0;
   int tmo_cyc = -1;

   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [2:0]  aw_size_q[$];
   logic [1:0]  aw_burst_q[$];
   int          aw_cyc_q[$];
   logic [3:0]  w_strb_q[$];
   logic        w_last_q[$];
   logic [31:0] w_data_q[$];
   int          w_cyc_q[$];
   logic [1:0]  resp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Handshakes seen at negedge are the ones the next posedge will complete.
   always @(negedge clk) begin
      if (axi.awvalid && axi.awready) begin
         aw_addr_q.push_back(axi.awaddr);
         aw_len_q.push_back(axi.awlen);
         aw_size_q.push_back(axi.awsize);
         aw_burst_q.push_back(axi.awburst);
         aw_cyc_q.push_back(cyc);
      end
      if (axi.wvalid && axi.wready) begin
         w_strb_q.push_back(axi.wstrb);
         w_last_q.push_back(axi.wlast);
         w_data_q.push_back(axi.wdata);
         w_cyc_q.push_back(cyc);
      end
      if (req.resp_valid) resp_q.push_back(req.resp);
`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
      if (timeout_o && tmo_cyc < 0) tmo_cyc = cyc;
`endif
   end

   task automatic clear_q();
      aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete(); aw_burst_q.delete(); aw_cyc_q.delete();
      w_strb_q.delete(); w_last_q.delete(); w_data_q.delete(); w_cyc_q.delete(); resp_q.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [15:0] len, input logic fx);
      int  n = 0;
      bit  done = 1'b0;
      req.addr = a; req.byte_len = len; req.fixed = fx; req.lock = 1'b0; req.valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (req.ready) done = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      req.valid = 1'b0;
      check("req_accept", done, 1);
   endtask

   task automatic send_b(input logic [1:0] r);
      axi.bvalid = 1'b1; axi.bresp = r;
      @(negedge clk); b_cyc = cyc;
      @(posedge clk); #1;
      axi.bvalid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 1'b0;
      req.addr = '0; req.byte_len = '0; req.fixed = 1'b0; req.lock = 1'b0; req.valid = 1'b0;

      // Reset state
      wait_cycles(3);
      @(negedge clk);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_wvalid", axi.wvalid, 0);
      check("rst_ready_o", ready_o, 0);
      check("rst_req_ready", req.ready, 0);
      check("rst_resp_valid", req.resp_valid, 0);
      check("rst_ostd", ostd_cnt, 0);
      check("rst_err", err_o, 0);
      @(posedge clk); #1;
      rst = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; valid_i = 1'b1;

      // Aligned INCR, 16 bytes: 4 full beats
      clear_q();
      do_req(32'h100, 16'd16, 1'b0);
      wait_cycles(8);
      check("al_aw_n", aw_addr_q.size(), 1);
      check("al_awaddr", aw_addr_q[0], 32'h100);
      check("al_awlen", aw_len_q[0], 3);
      check("al_awsize", aw_size_q[0], 2);
      check("al_awburst", aw_burst_q[0], 1);
      check("al_beats", w_strb_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("al_wstrb", w_strb_q[i], 4'hF);
         check("al_wlast", w_last_q[i], (i == 3));
      end
      check("al_wdata", w_data_q[0], 32'hCAFE_0001);
      check("al_w_after_aw", w_cyc_q[0], aw_cyc_q[0] + 1);
      send_b(2'b00);
      wait_cycles(3);
      check("al_resp_n", resp_q.size(), 1);
      check("al_resp", resp_q[0], 0);
      check("al_ostd0", ostd_cnt, 0);

      // Unaligned 0x103, 6 bytes: partial first and last lanes
      clear_q();
      do_req(32'h103, 16'd6, 1'b0);
      wait_cycles(8);
      check("ua_awaddr", aw_addr_q[0], 32'h103);
      check("ua_awlen", aw_len_q[0], 2);
      check("ua_pops", w_strb_q.size(), 3);
      check("ua_strb0", w_strb_q[0], 4'h8);
      check("ua_strb1", w_strb_q[1], 4'hF);
      check("ua_strb2", w_strb_q[2], 4'h1);
      send_b(2'b00);
      wait_cycles(2);

      // FIXED burst of 2 aligned beats
      clear_q();
      do_req(32'h500, 16'd8, 1'b1);
      wait_cycles(6);
      check("fx_awburst", aw_burst_q[0], 0);
      check("fx_awlen", aw_len_q[0], 1);
      check("fx_strb0", w_strb_q[0], 4'hF);
      check("fx_strb1", w_strb_q[1], 4'hF);
      send_b(2'b00);
      wait_cycles(2);

      // Outstanding limit: six single-beat bursts with B held back
      clear_q();
      fork
         begin
            for (int i = 0; i < 6; i++) do_req(32'h200 + 32'(i) * 32'd16, 16'd4, 1'b0);
         end
         begin
            wait_cycles(20);
            @(negedge clk);
            check("os_aw_n4", aw_addr_q.size(), 4);
            check("os_cnt4", ostd_cnt, 4);
            check("os_ready0", req.ready, 0);
            @(posedge clk); #1;
            send_b(2'b00);
            wait_cycles(3);
            check("os_aw_n5", aw_addr_q.size(), 5);
            check("os_aw5_cyc", (aw_cyc_q.size() > 4) ? aw_cyc_q[4] : -1, b_cyc + 1);
            for (int k = 0; k < 5; k++) begin
               send_b(2'b00);
               wait_cycles(3);
            end
         end
      join
      wait_cycles(2);
      check("os_aw_n6", aw_addr_q.size(), 6);
      check("os_resp_n", resp_q.size(), 6);
      check("os_cnt0", ostd_cnt, 0);

      // Back-to-back 2-beat bursts released together
      clear_q();
      axi.wready = 1'b0; valid_i = 1'b0;
      do_req(32'h400, 16'd8, 1'b0);
      do_req(32'h408, 16'd8, 1'b0);
      wait_cycles(3);
      @(negedge clk);
      check("bb_wvalid_nodata", axi.wvalid, 0);
      @(posedge clk); #1;
      valid_i = 1'b1;
      @(negedge clk);
      check("bb_wvalid", axi.wvalid, 1);
      check("bb_ready_o_stall", ready_o, 0);
      @(posedge clk); #1;
      axi.wready = 1'b1;
      wait_cycles(6);
      check("bb_beats", w_last_q.size(), 4);
      check("bb_lasts", {w_last_q[0], w_last_q[1], w_last_q[2], w_last_q[3]}, 4'b0101);
      check("bb_no_bubble", w_cyc_q[3] - w_cyc_q[0], 3);
      send_b(2'b00);
      send_b(2'b00);
      wait_cycles(2);

      // Error response is sticky through later OKAYs
      clear_q();
      for (int i = 0; i < 3; i++) do_req(32'h800 + 32'(i) * 32'd4, 16'd4, 1'b0);
      wait_cycles(4);
      send_b(2'b00);
      wait_cycles(1);
      send_b(2'b10);
      wait_cycles(1);
      check("er_err_set", err_o, 1);
      send_b(2'b00);
      wait_cycles(3);
      check("er_resp_n", resp_q.size(), 3);
      check("er_resp1", resp_q[1], 2);
      check("er_resp2", resp_q[2], 0);
      check("er_err_sticky", err_o, 1);

      // Reset mid-burst
      clear_q();
      axi.wready = 1'b0;
      do_req(32'h600, 16'd16, 1'b0);
      wait_cycles(3);
      @(negedge clk);
      check("rs_pre_wvalid", axi.wvalid, 1);
      check("rs_pre_ostd", ostd_cnt, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rs_wvalid", axi.wvalid, 0);
      check("rs_ostd", ostd_cnt, 0);
      check("rs_err", err_o, 0);
      @(posedge clk); #1;
      rst = 1'b0; axi.wready = 1'b1;
      clear_q();
      wait_cycles(5);
      check("rs_no_w", w_strb_q.size(), 0);
      check("rs_awvalid", axi.awvalid, 0);

`ifdef AXI_MGR_WR_BRESP_TIMEOUT_EN
      // B watchdog: timeout_o rises 8 edges after the AW handshake edge
      clear_q();
      do_req(32'h700, 16'd4, 1'b0);
      wait_cycles(14);
      check("to_aw_n", aw_cyc_q.size(), 1);
      check("to_cyc", tmo_cyc, aw_cyc_q[0] + 9);
      @(negedge clk);
      check("to_flag", timeout_o, 1);
      check("to_ready0", req.ready, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/axi_mgr_wr_ostd.md
Name: axi_mgr_wr_ostd

Overview:
- Parametrised AXI4 write manager for DMA write paths.
- Accepts burst requests from the DMA FSM and issues each AW without waiting for earlier bursts; keeps up to MAX_OSTD bursts in flight.
- Streams write data from a FIFO, generating byte strobes for unaligned start and end addresses.
- Tracks write responses per burst and reports one response per request plus a sticky error flag.

Parameters:
- AW, 32, address width
- DW, 32, data width; BC = DW/8 bytes per beat, BW = $clog2(BC)
- UW, 32, user width
- IW, 1, ID width
- MAX_OSTD, 4, maximum bursts issued but not yet B-responded; power of 2, range 1..16

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- m_axi_if  modport axi_if.w_mgr  -  AXI4 AW/W/B manager channels
- req_if  modport axi_dma_req_if.snk  -  request (addr, byte_len, fixed, lock, valid/ready) and response (resp, resp_valid)
- axuser  input  UW  static AWUSER/WUSER value
- valid_i  input  1  FIFO data valid
- data_i  input  DW  FIFO data, lane-aligned to the AXI byte lanes
- ready_o  output  1  FIFO pop; a pop occurs when valid_i && ready_o
- ostd_cnt_o  output  $clog2(MAX_OSTD)+1  bursts awaiting B
- err_o  output  1  sticky: any BRESP of SLVERR or DECERR

Behaviour:
- Reset values: awvalid=0, wvalid=0, ready_o=0, req_if.ready=0, resp_valid=0, ostd_cnt_o=0, err_o=0. Reset mid-burst abandons all state and empties the context FIFO; no W beats are emitted after reset.
- Beat count:
  - beats = ceil((addr[BW-1:0] + byte_len) / BC); awlen = beats-1.
  - fixed=1 forces the offset term to 0.
  - byte_len=0 is illegal (asserted).
  - Bursts must not cross 4 KB for INCR and must satisfy awlen <= 255 (INCR) or <= 15 (FIXED) (asserted).
- AW fields: awaddr = req addr, unmodified. awsize = BW. awburst = FIXED or INCR. awid = 0. awlock = lock. awuser = axuser.
- Request acceptance:
  - req_if.ready = !rst && (ostd_cnt < MAX_OSTD) && ctx FIFO not full && (!awvalid || awready).
  - An accepted request registers AW, so awvalid rises the next cycle and stays high until awready.
  - AW issue has 1-cycle latency.
- Context FIFO:
  - Depth MAX_OSTD. Each entry holds {beats-1, first strobe, last strobe, fixed}.
  - Pushed on the AW handshake; popped on the W handshake with wlast.
- W channel:
  - Active while the ctx FIFO is non-empty. wvalid = active && valid_i. ready_o = active && wready. wdata = data_i. wuser = axuser.
  - wlast asserts when the beat down-counter equals 0.
  - W data may lead AW by at most zero bursts: W for a burst starts no earlier than the cycle after its AW handshake.
- Strobes:
  - first = '1 << addr[BW-1:0].
  - last = '1 >> (BC-1 - end[BW-1:0]), where end = addr+byte_len-1.
  - A single-beat burst uses first & last. Middle beats use '1.
  - fixed=1: every beat uses '1; requests with fixed=1 must be BC-aligned in both addr and byte_len (asserted).
- Back-to-back bursts: the next burst's first beat may follow the previous wlast in the very next cycle, with no bubble.
- Outstanding counter:
  - +1 on the AW handshake, -1 on the B handshake, net 0 when both occur in the same cycle.
  - Saturation at MAX_OSTD blocks req_if.ready.
- B channel:
  - bready = 1. Each B handshake drives resp_valid=1 and resp=bresp for exactly one cycle; responses come back in order (single ID).
  - err_o sets on BRESP[1]=1 and clears only on rst.
  - A B arriving while ostd_cnt=0 is illegal (asserted, ignored).
- Assertions: ready_o implies active; wvalid never without valid_i; no AW while ostd_cnt==MAX_OSTD; ctx FIFO never overflows.

Optional Feature:
- AXI_MGR_WR_BRESP_TIMEOUT_EN, when defined:
  - Adds parameter TIMEOUT (default 1024) and output port timeout_o.
  - A counter runs whenever ostd_cnt>0 and no B handshake occurs in the cycle; any B handshake or ostd_cnt==0 clears it.
  - On reaching TIMEOUT, timeout_o sets (sticky until rst) and req_if.ready is forced to 0.
- When not defined: no port, no counter; timeout_o absent.

Test Plan:
- Aligned INCR, addr=0x100, byte_len=16, DW=32: AW has awlen=3, awsize=2; 4 W beats with wstrb=0xF; wlast on beat 4; one resp_valid with OKAY.
- Unaligned, addr=0x103, byte_len=6: awlen=2; wstrb=0x8, 0xF, 0x1; exactly 3 FIFO pops.
- MAX_OSTD=4, B withheld, 6 requests queued: 4 AWs issue; req_if.ready stays 0 with ostd_cnt_o=4; the 5th AW issues the cycle after the first B.
- Back-to-back 2-beat bursts with wready=1 and valid_i=1: wvalid continuous, wlast on beats 2 and 4, no idle cycle between them.
- Second B returns SLVERR: resp_valid pulse carries resp=2; err_o=1 persists through later OKAY responses; rst asserted mid-burst clears wvalid, ostd_cnt_o and err_o on the next edge.
- With AXI_MGR_WR_BRESP_TIMEOUT_EN and TIMEOUT=8: one burst sent, B withheld; timeout_o=1 exactly 8 cycles after the AW handshake, and req_if.ready=0 afterwards.
